lockin_amplitude_mc: RTL and testbench
======================================

// Module: lockin_amplitude_mc
// PURPOSE
//  Multi-channel lock-in magnitude engine: takes per-channel in-phase/quadrature
//  accumulator results (I,Q), computes A = floor(sqrt(I'^2+Q'^2))*GAIN >> GAIN_SHIFT
//  with I'=I>>>DIV_SHIFT, Q'=Q>>>DIV_SHIFT. Sits after the lock-in accumulators,
//  shared by all SSVEP channels via valid/ready handshake; keeps a per-channel
//  bank of the latest amplitude for the readout/control side.
// PARAMETERS
//  W_IN        32  signed width of I and Q inputs (even, >=8)
//  N_CH         4  number of channels (bank depth), >=2
//  DIV_SHIFT    0  arithmetic right shift applied to I,Q (normalisation by N*M)
//  GAIN         1  unsigned integer multiplier applied to root (< 2^16)
//  GAIN_SHIFT   0  right shift after GAIN (fixed-point scale)
//  W_OUT       32  output amplitude width (unsigned)
// PORTS
//  Clock      in   1         rising-edge clock
//  reset_n    in   1         asynchronous active-low reset
//  in_valid   in   1         I/Q/channel present
//  in_ready   out  1         engine idle; sample accepted when in_valid&in_ready
//  in_ch      in   CH_W      channel tag, CH_W=$clog2(N_CH)
//  in_fase    in   W_IN      signed in-phase result I
//  in_cuad    in   W_IN      signed quadrature result Q
//  out_valid  out  1         result available, held until out_ready
//  out_ready  in   1         downstream accepts result
//  out_ch     out  CH_W      tag of the result
//  out_amp    out  W_OUT     amplitude A, saturated
//  out_sat    out  1         A exceeded 2^W_OUT-1 and was clamped
//  rd_ch      in   CH_W      bank read address
//  rd_amp     out  W_OUT     combinational read of bank[rd_ch]
// BEHAVIOUR
//  Reset: state IDLE, in_ready=1, out_valid=0, out_ch=0, out_amp=0, out_sat=0,
//   all bank entries 0, all internal datapath regs 0. Applies mid-operation: the
//   in-flight sample is discarded, no output produced.
//  FSM: IDLE -(in_valid)-> LOAD -> SQUARE -> SQRT (W_IN cycles) -> SCALE -> HOLD
//   -(out_ready)-> IDLE. in_ready = (state==IDLE); inputs registered only on accept.
//  LOAD: I',Q' = arithmetic shift; magnitudes |I'|,|Q'| in W_IN bits (unsigned,
//   so -2^(W_IN-1) is exact).
//  SQUARE: S = |I'|^2 + |Q'|^2 in 2*W_IN bits unsigned; cannot overflow.
//  SQRT: non-restoring, 2 bits of S per cycle, counter 0..W_IN-1; root R is W_IN
//   bits, R = floor(sqrt(S)) exactly; remainder discarded.
//  SCALE: P = (R*GAIN) >> GAIN_SHIFT (W_IN+16 bits); if P > 2^W_OUT-1 then
//   out_amp = all ones, out_sat=1, else out_amp = P, out_sat=0.
//  On SCALE->HOLD edge: out_valid<=1, out_ch, out_amp, out_sat loaded; bank[out_ch]
//   <= same value (write skipped if out_ch >= N_CH).
//  Latency: out_valid rises W_IN+4 cycles after the accepting edge (36 default).
//  HOLD: outputs stable while out_valid&~out_ready; on handshake edge out_valid<=0,
//   state IDLE, in_ready=1 next cycle. Min interval between accepts: W_IN+5 cycles.
//  in_valid while busy: ignored (not latched); source must hold until in_ready.
//  rd_amp reflects bank write in the cycle after the write edge; rd_ch >= N_CH -> 0.
// TESTING
//  I=3,Q=-4,ch=1 -> after 36 cycles out_valid=1, out_amp=5, out_ch=1, out_sat=0; rd_ch=1 -> 5
//  I=0,Q=0 -> out_amp=0; I=10,Q=10 -> out_amp=14 (floor, no rounding)
//  I=Q=-2^31 -> out_amp=3037000499, out_sat=0 (full-scale, unsigned abs path)
//  W_OUT=16, GAIN=2: I=40000,Q=0 -> out_amp=65535, out_sat=1; bank[ch]=65535
//  out_ready low 10 cycles -> out_* stable, in_ready=0, second in_valid not accepted
//   until cycle after handshake; back-to-back samples ch0,ch2 land in correct bank slots
//  reset_n pulsed low mid-SQRT -> out_valid=0, in_ready=1, bank all 0, no stale result

Source files
------------

// File: rtl/lockin_amplitude_mc_if.sv
// Handshake bundle between the lock-in accumulators, the magnitude engine and the readout side.
// master = sample source / result sink / bank reader, slave = the magnitude engine.
interface lockin_amplitude_mc_if #(
    parameter int W_IN  = 32,
    parameter int W_OUT = 32,
    parameter int CH_W  = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [CH_W-1:0]         in_ch;
    logic signed [W_IN-1:0]  in_fase;
    logic signed [W_IN-1:0]  in_cuad;
    logic                    out_valid;
    logic                    out_ready;
    logic [CH_W-1:0]         out_ch;
    logic [W_OUT-1:0]        out_amp;
    logic                    out_sat;
    logic [CH_W-1:0]         rd_ch;
    logic [W_OUT-1:0]        rd_amp;

    modport master (
        output in_valid, in_ch, in_fase, in_cuad, out_ready, rd_ch,
        input  in_ready, out_valid, out_ch, out_amp, out_sat, rd_amp
    );

    modport slave (
        input  in_valid, in_ch, in_fase, in_cuad, out_ready, rd_ch,
        output in_ready, out_valid, out_ch, out_amp, out_sat, rd_amp
    );
endinterface

// File: rtl/lockin_amplitude_mc.sv
// Shared lock-in magnitude engine: A = floor(sqrt(I'^2+Q'^2))*GAIN >> GAIN_SHIFT, plus per-channel result bank.
// Latency: result registered W_IN+3 edges after the accepting edge (visible in the (W_IN+4)th cycle).
// Backpressure: single sample in flight; in_ready low from accept until the output handshake completes.
module lockin_amplitude_mc #(
    parameter int W_IN       = 32,
    parameter int N_CH       = 4,
    parameter int DIV_SHIFT  = 0,
    parameter int GAIN       = 1,
    parameter int GAIN_SHIFT = 0,
    parameter int W_OUT      = 32
) (
    input  logic                  Clock,
    input  logic                  reset_n,
    lockin_amplitude_mc_if.slave  bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int SW   = 2 * W_IN;
    localparam int RW   = W_IN + 3;
    localparam int PW   = W_IN + 16;
    localparam int CW   = $clog2(W_IN);

    typedef enum logic [2:0] {IDLE, LOAD, SQUARE, SQRT, SCALE, HOLD} state_t;

    state_t                  state;
    logic                    rdy_q;
    logic                    vld_q;
    logic [CH_W-1:0]         ch_q;
    logic [CH_W-1:0]         out_ch_q;
    logic signed [W_IN-1:0]  fase_q;
    logic signed [W_IN-1:0]  cuad_q;
    logic [W_IN-1:0]         mag_i;
    logic [W_IN-1:0]         mag_q;
    logic [SW-1:0]           s_q;
    logic [RW-1:0]           rem_q;
    logic [W_IN-1:0]         root_q;
    logic [CW-1:0]           cnt_q;
    logic [W_OUT-1:0]        amp_q;
    logic                    sat_q;
    logic [W_OUT-1:0]        bank [N_CH];

    logic signed [W_IN-1:0]  fase_sh;
    logic signed [W_IN-1:0]  cuad_sh;
    logic [W_IN-1:0]         abs_i;
    logic [W_IN-1:0]         abs_q;
    logic [SW-1:0]           sum_sq;
    logic [RW-1:0]           rem_sh;
    logic [RW-1:0]           rem_nx;
    logic [W_IN-1:0]         root_nx;
    logic [PW-1:0]           prod;
    logic                    sat_nx;
    logic [W_OUT-1:0]        amp_nx;
    logic                    wr_ok;

    // Magnitudes kept unsigned so the most negative input maps to 2^(W_IN-1) exactly.
    assign fase_sh = fase_q >>> DIV_SHIFT;
    assign cuad_sh = cuad_q >>> DIV_SHIFT;
    assign abs_i   = fase_sh[W_IN-1] ? $unsigned(-fase_sh) : $unsigned(fase_sh);
    assign abs_q   = cuad_sh[W_IN-1] ? $unsigned(-cuad_sh) : $unsigned(cuad_sh);
    assign sum_sq  = (SW'(mag_i) * SW'(mag_i)) + (SW'(mag_q) * SW'(mag_q));

    // Non-restoring root step: remainder sign (MSB) picks add or subtract; root bit is the new sign inverted.
    assign rem_sh  = (rem_q << 2) | RW'(s_q[SW-1 -: 2]);
    assign rem_nx  = rem_q[RW-1] ? (rem_sh + RW'({root_q, 2'b11}))
                                 : (rem_sh - RW'({root_q, 2'b01}));
    assign root_nx = {root_q[W_IN-2:0], ~rem_nx[RW-1]};

    assign prod    = (PW'(root_q) * PW'(GAIN)) >> GAIN_SHIFT;
    assign sat_nx  = (prod >> W_OUT) != '0;
    assign amp_nx  = sat_nx ? '1 : W_OUT'(prod);
    assign wr_ok   = 32'(ch_q) < 32'(N_CH);

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = vld_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_amp   = amp_q;
    assign bus.out_sat   = sat_q;
    assign bus.rd_amp    = (32'(bus.rd_ch) < 32'(N_CH)) ? bank[bus.rd_ch] : '0;

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rdy_q    <= 1'b1;
            vld_q    <= 1'b0;
            ch_q     <= '0;
            out_ch_q <= '0;
            fase_q   <= '0;
            cuad_q   <= '0;
            mag_i    <= '0;
            mag_q    <= '0;
            s_q      <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            cnt_q    <= '0;
            amp_q    <= '0;
            sat_q    <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                bank[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        fase_q <= bus.in_fase;
                        cuad_q <= bus.in_cuad;
                        ch_q   <= bus.in_ch;
                        rdy_q  <= 1'b0;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    mag_i <= abs_i;
                    mag_q <= abs_q;
                    state <= SQUARE;
                end
                SQUARE: begin
                    s_q    <= sum_sq;
                    rem_q  <= '0;
                    root_q <= '0;
                    cnt_q  <= '0;
                    state  <= SQRT;
                end
                SQRT: begin
                    s_q    <= s_q << 2;
                    rem_q  <= rem_nx;
                    root_q <= root_nx;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(W_IN - 1)) begin
                        state <= SCALE;
                    end
                end
                SCALE: begin
                    vld_q    <= 1'b1;
                    out_ch_q <= ch_q;
                    amp_q    <= amp_nx;
                    sat_q    <= sat_nx;
                    if (wr_ok) begin
                        bank[ch_q] <= amp_nx;
                    end
                    state    <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        vld_q <= 1'b0;
                        rdy_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    rdy_q <= 1'b1;
                    vld_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lockin_amplitude_mc.sv
// Scoreboard bench: two engine configurations driven in lockstep, outputs checked against a sqrt reference model.
module tb_lockin_amplitude_mc;
    localparam int W_IN = 32;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] amp;
        logic        sat;
        int          acc;
    } exp_t;

    logic Clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 Clock = ~Clock;

    lockin_amplitude_mc_if #(.W_IN(32), .W_OUT(32), .CH_W(2)) bus_a ();
    lockin_amplitude_mc_if #(.W_IN(32), .W_OUT(16), .CH_W(2)) bus_b ();

    lockin_amplitude_mc #(.W_IN(32), .N_CH(4), .DIV_SHIFT(0), .GAIN(1), .GAIN_SHIFT(0), .W_OUT(32))
        dut_a (.Clock(Clock), .reset_n(reset_n), .bus(bus_a));
    lockin_amplitude_mc #(.W_IN(32), .N_CH(3), .DIV_SHIFT(0), .GAIN(2), .GAIN_SHIFT(0), .W_OUT(16))
        dut_b (.Clock(Clock), .reset_n(reset_n), .bus(bus_b));

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   last_acc;
    int   last_hs [2];
    bit   force_stall = 1'b0;
    exp_t q0 [$];
    exp_t q1 [$];
    logic [31:0] bm0 [4];
    logic [31:0] bm1 [4];
    bit          prev_v [2];
    bit          hold_f [2];
    logic [1:0]  prev_ch [2];
    logic [31:0] prev_amp [2];
    logic        prev_sat [2];

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: integer square root by binary search on 64-bit sums, then gain and clamp.
    function automatic void model(input int k, input logic signed [31:0] i, input logic signed [31:0] q,
                                  output logic [31:0] amp, output logic sat);
        longint si, sq;
        logic [63:0] ai, aq, s, lo, hi, mid, p, mx;
        int gain, wout, div;
        gain = (k == 0) ? 1 : 2;
        wout = (k == 0) ? 32 : 16;
        div  = 0;
        si = longint'(i) >>> div;
        sq = longint'(q) >>> div;
        ai = (si < 0) ? 64'(-si) : 64'(si);
        aq = (sq < 0) ? 64'(-sq) : 64'(sq);
        s  = ai * ai + aq * aq;
        lo = 64'd0;
        hi = 64'h1_0000_0000;
        while (hi - lo > 64'd1) begin
            mid = (lo + hi) >> 1;
            if (mid * mid <= s) lo = mid;
            else hi = mid;
        end
        p   = lo * 64'(gain);
        mx  = (64'd1 << wout) - 64'd1;
        sat = p > mx;
        amp = sat ? mx[31:0] : p[31:0];
    endfunction

    task automatic mon(input int k, input logic ov, input logic ordy, input logic [1:0] och,
                       input logic [31:0] oamp, input logic osat, input logic irdy);
        exp_t e;
        int   n;
        if (!reset_n) begin
            prev_v[k] = 1'b0;
            hold_f[k] = 1'b0;
            return;
        end
        if (hold_f[k]) begin
            chk($sformatf("hold_valid%0d", k), 64'(ov), 64'(1'b1));
            chk($sformatf("hold_stable%0d", k), {och, osat, oamp}, {prev_ch[k], prev_sat[k], prev_amp[k]});
            chk($sformatf("hold_in_ready%0d", k), 64'(irdy), 64'(1'b0));
        end
        if (ov && !prev_v[k]) begin
            n = (k == 0) ? q0.size() : q1.size();
            checks++;
            if (n == 0) begin
                errors++;
                $display("FAIL unexpected_out%0d actual=valid required=no_output ch=%0d amp=%0d", k, och, oamp);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("out_ch%0d", k), 64'(och), 64'(e.ch));
                chk($sformatf("out_amp%0d", k), 64'(oamp), 64'(e.amp));
                chk($sformatf("out_sat%0d", k), 64'(osat), 64'(e.sat));
                chk($sformatf("latency%0d", k), 64'(cyc - e.acc), 64'(W_IN + 3));
                if (k == 0) bm0[e.ch] = e.amp;
                else if (e.ch < 2'd3) bm1[e.ch] = e.amp;
            end
        end
        if (ov && ordy) last_hs[k] = cyc + 1;
        hold_f[k]   = ov && !ordy;
        prev_v[k]   = ov;
        prev_ch[k]  = och;
        prev_amp[k] = oamp;
        prev_sat[k] = osat;
    endtask

    always @(negedge Clock) begin
        mon(0, bus_a.out_valid, bus_a.out_ready, bus_a.out_ch, bus_a.out_amp, bus_a.out_sat, bus_a.in_ready);
        mon(1, bus_b.out_valid, bus_b.out_ready, bus_b.out_ch, 32'(bus_b.out_amp), bus_b.out_sat, bus_b.in_ready);
    end

    initial begin
        bus_a.out_ready = 1'b0;
        bus_b.out_ready = 1'b0;
        forever begin
            @(posedge Clock);
            #2;
            bus_a.out_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            bus_b.out_ready = bus_a.out_ready;
        end
    end

    task automatic drive(input logic v, input logic signed [31:0] i, input logic signed [31:0] q,
                         input logic [1:0] ch);
        bus_a.in_valid = v; bus_a.in_fase = i; bus_a.in_cuad = q; bus_a.in_ch = ch;
        bus_b.in_valid = v; bus_b.in_fase = i; bus_b.in_cuad = q; bus_b.in_ch = ch;
    endtask

    task automatic send(input logic signed [31:0] i, input logic signed [31:0] q, input logic [1:0] ch);
        exp_t e;
        int   n;
        @(negedge Clock);
        drive(1'b1, i, q, ch);
        n = 0;
        while (!bus_a.in_ready && n < 300) begin
            @(negedge Clock);
            n++;
        end
        if (n >= 300) begin
            chk("accept_timeout", 64'(n), 64'(0));
            drive(1'b0, 0, 0, 2'd0);
            return;
        end
        @(posedge Clock);
        #1;
        last_acc = cyc;
        e.ch = ch; e.acc = cyc;
        model(0, i, q, e.amp, e.sat);
        q0.push_back(e);
        model(1, i, q, e.amp, e.sat);
        q1.push_back(e);
        @(negedge Clock);
        drive(1'b0, 0, 0, 2'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || !bus_a.in_ready) && n < 500) begin
            @(negedge Clock);
            n++;
        end
        chk("idle_reached", 64'(n < 500), 64'(1'b1));
    endtask

    task automatic check_bank();
        for (int c = 0; c < 4; c++) begin
            bus_a.rd_ch = 2'(c);
            bus_b.rd_ch = 2'(c);
            #1;
            chk($sformatf("bank_a[%0d]", c), 64'(bus_a.rd_amp), 64'(bm0[c]));
            chk($sformatf("bank_b[%0d]", c), 64'(bus_b.rd_amp), 64'(bm1[c]));
        end
    endtask

    initial begin
        logic signed [31:0] ri, rq;
        logic signed [31:0] ext [4];
        ext[0] = 32'sh8000_0000; ext[1] = 32'sh7fff_ffff; ext[2] = 32'sd0; ext[3] = -32'sd1;
        for (int c = 0; c < 4; c++) begin
            bm0[c] = '0;
            bm1[c] = '0;
        end
        drive(1'b0, 0, 0, 2'd0);
        bus_a.rd_ch = 2'd0;
        bus_b.rd_ch = 2'd0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("rst_in_ready", 64'(bus_a.in_ready & bus_b.in_ready), 64'(1'b1));
        chk("rst_out_valid", 64'(bus_a.out_valid | bus_b.out_valid), 64'(1'b0));
        chk("rst_out_ch", 64'({bus_a.out_ch, bus_b.out_ch}), 64'(0));
        chk("rst_out_amp", 64'(bus_a.out_amp) + 64'(bus_b.out_amp), 64'(0));
        chk("rst_out_sat", 64'(bus_a.out_sat | bus_b.out_sat), 64'(1'b0));
        check_bank();
        @(posedge Clock);
        #2 reset_n = 1'b1;

        // Directed corner values.
        send(32'sd3, -32'sd4, 2'd1);      wait_idle(); check_bank();
        send(32'sd0, 32'sd0, 2'd0);       wait_idle();
        send(32'sd10, 32'sd10, 2'd2);     wait_idle();
        send(32'sh8000_0000, 32'sh8000_0000, 2'd3); wait_idle();
        send(32'sd40000, 32'sd0, 2'd1);   wait_idle(); check_bank();

        // Long output stall with a second sample waiting; back-to-back ch0 then ch2.
        force_stall = 1'b1;
        send(32'sd1234, -32'sd5678, 2'd0);
        begin
            int n;
            n = 0;
            while (!bus_a.out_valid && n < 100) begin
                @(negedge Clock);
                n++;
            end
            chk("stall_out_seen", 64'(n < 100), 64'(1'b1));
        end
        fork
            send(-32'sd99999, 32'sd777, 2'd2);
            begin
                repeat (10) @(posedge Clock);
                force_stall = 1'b0;
            end
        join
        chk("accept_after_hs", 64'(last_acc - last_hs[0]), 64'(1));
        wait_idle(); check_bank();

        // Randomised traffic with random downstream backpressure.
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0: begin ri = $urandom; rq = $urandom; end
                1: begin ri = $urandom_range(0, 2000) - 1000; rq = $urandom_range(0, 2000) - 1000; end
                2: begin ri = ext[$urandom_range(0, 3)]; rq = ext[$urandom_range(0, 3)]; end
                default: begin
                    ri = $urandom_range(32760, 32775);
                    rq = $urandom_range(0, 1) ? 32'sd0 : -32'sd3;
                    if ($urandom_range(0, 1) != 0) ri = -ri;
                end
            endcase
            send(ri, rq, 2'($urandom_range(0, 3)));
        end
        wait_idle(); check_bank();

        // Reset in the middle of the root iterations: nothing may come out afterwards.
        send(32'sd7777, -32'sd1234, 2'd2);
        repeat (10) @(posedge Clock);
        #2 reset_n = 1'b0;
        q0.delete();
        q1.delete();
        for (int c = 0; c < 4; c++) begin
            bm0[c] = '0;
            bm1[c] = '0;
        end
        @(negedge Clock);
        chk("midrst_out_valid", 64'(bus_a.out_valid | bus_b.out_valid), 64'(1'b0));
        chk("midrst_in_ready", 64'(bus_a.in_ready & bus_b.in_ready), 64'(1'b1));
        check_bank();
        @(posedge Clock);
        #2 reset_n = 1'b1;
        repeat (60) @(posedge Clock);
        @(negedge Clock);
        chk("post_rst_no_output", 64'(bus_a.out_valid | bus_b.out_valid), 64'(1'b0));
        check_bank();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
